branch_predictor: RTL and testbench

//  Two-bit saturating-counter branch predictor with direct-mapped branch target buffer (BTB).
//  IF stage: combinational lookup of the fetch PC; supplies predicted direction and next PC.
//  EX stage: consumes the resolved outcome (ALU br_sel, ALU target); trains the tables.

---
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor with a direct-mapped BTB.
// The IF side does a zero-latency lookup of the fetch PC. The EX side trains the
// tables from resolved branches and raises a flush with the corrected PC.
module branch_predictor #(
  parameter int NUM_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_if_pc,
  output logic              o_pred_taken,
  output logic [31:0]       o_pred_pc,
  input  logic              i_ex_valid,
  input  logic              i_ex_branch,
  input  logic [31:0]       i_ex_pc,
  input  logic              i_ex_br_sel,
  input  logic [31:0]       i_ex_target,
  input  logic              i_ex_pred_taken,
  input  logic [31:0]       i_ex_pred_pc,
  output logic              o_mispredict,
  output logic [31:0]       o_redirect_pc,
  output logic [CNT_W-1:0]  o_br_count,
  output logic [CNT_W-1:0]  o_miss_count
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  // Per-entry prediction state
  logic              r_valid  [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_tag    [NUM_ENTRIES];
  logic [31:0]       r_target [NUM_ENTRIES];
  logic [1:0]        r_ctr    [NUM_ENTRIES];

  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic [IDX_W-1:0]  w_if_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic              w_if_hit;
  logic [31:0]       w_if_pc_plus4;

  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_ex_hit;
  logic [31:0]       w_ex_pc_plus4;
  logic              w_upd;
  logic              w_mispredict;

  assign w_if_idx      = i_if_pc[IDX_W+1:2];
  assign w_if_tag      = i_if_pc[31:IDX_W+2];
  assign w_if_pc_plus4 = i_if_pc + 32'd4;

  assign w_ex_idx      = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag      = i_ex_pc[31:IDX_W+2];
  assign w_ex_pc_plus4 = i_ex_pc + 32'd4;

  assign w_upd = i_ex_valid & i_ex_branch;

  // IF lookup: reads the registered tables, so a same-cycle update is not yet visible
  always_comb begin
    w_if_hit     = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    o_pred_taken = w_if_hit & r_ctr[w_if_idx][1];
    o_pred_pc    = o_pred_taken ? r_target[w_if_idx] : w_if_pc_plus4;
  end

  // EX resolution: flush on wrong direction or on a taken branch with the wrong target
  always_comb begin
    w_ex_hit      = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    w_mispredict  = i_rst_n & w_upd &
                    ((i_ex_pred_taken != i_ex_br_sel) |
                     (i_ex_br_sel & (i_ex_pred_pc != i_ex_target)));
    o_mispredict  = w_mispredict;
    o_redirect_pc = 32'd0;
    if (w_mispredict) begin
      o_redirect_pc = i_ex_br_sel ? i_ex_target : w_ex_pc_plus4;
    end
  end

  // Table training: step the counter on a hit, allocate only on a taken miss
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        if (i_ex_br_sel) begin
          r_target[w_ex_idx] <= i_ex_target;
          if (r_ctr[w_ex_idx] != CTR_MAX) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
          end
        end else if (r_ctr[w_ex_idx] != CTR_MIN) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
      end else if (i_ex_br_sel) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= i_ex_target;
        r_ctr[w_ex_idx]    <= CTR_ALLOC;
      end
    end
  end

  // Performance counters, free-running and wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_upd) begin
        r_br_count <= r_br_count + 1'b1;
      end
      if (w_mispredict) begin
        r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  assign o_br_count   = r_br_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (NUM_ENTRIES=64, CNT_W=32).
module tb_branch_predictor;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_pc;
  logic        i_ex_valid;
  logic        i_ex_branch;
  logic [31:0] i_ex_pc;
  logic        i_ex_br_sel;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_pc;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_br_count;
  logic [31:0] o_miss_count;

  int nCompared;
  int nMismatched;

  branch_predictor #(.NUM_ENTRIES(64), .CNT_W(32)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_if_pc         (i_if_pc),
    .o_pred_taken    (o_pred_taken),
    .o_pred_pc       (o_pred_pc),
    .i_ex_valid      (i_ex_valid),
    .i_ex_branch     (i_ex_branch),
    .i_ex_pc         (i_ex_pc),
    .i_ex_br_sel     (i_ex_br_sel),
    .i_ex_target     (i_ex_target),
    .i_ex_pred_taken (i_ex_pred_taken),
    .i_ex_pred_pc    (i_ex_pred_pc),
    .o_mispredict    (o_mispredict),
    .o_redirect_pc   (o_redirect_pc),
    .o_br_count      (o_br_count),
    .o_miss_count    (o_miss_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exIdle();
    i_ex_valid      = 1'b0;
    i_ex_branch     = 1'b0;
    i_ex_pc         = 32'd0;
    i_ex_br_sel     = 1'b0;
    i_ex_target     = 32'd0;
    i_ex_pred_taken = 1'b0;
    i_ex_pred_pc    = 32'd0;
  endtask

  task automatic exDrive(input logic [31:0] pc, input logic brSel, input logic [31:0] tgt,
                         input logic predT, input logic [31:0] predPc);
    i_ex_valid      = 1'b1;
    i_ex_branch     = 1'b1;
    i_ex_pc         = pc;
    i_ex_br_sel     = brSel;
    i_ex_target     = tgt;
    i_ex_pred_taken = predT;
    i_ex_pred_pc    = predPc;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic expT,
                        input logic [31:0] expPc);
    i_if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, expT});
    chk({tag, "_pc"}, o_pred_pc, expPc);
  endtask

  task automatic exCheck(input string tag, input logic expMp, input logic [31:0] expRed);
    #1;
    chk({tag, "_mp"}, {31'd0, o_mispredict}, {31'd0, expMp});
    chk({tag, "_redir"}, o_redirect_pc, expRed);
  endtask

  task automatic cntCheck(input string tag, input int expBr, input int expMiss);
    chk({tag, "_br"}, o_br_count, expBr);
    chk({tag, "_miss"}, o_miss_count, expMiss);
  endtask

  // Drive EX for one cycle, check the comb flush outputs, then clock it in
  task automatic exStep(input string tag, input logic [31:0] pc, input logic brSel,
                        input logic [31:0] tgt, input logic predT, input logic [31:0] predPc,
                        input logic expMp, input logic [31:0] expRed);
    @(negedge i_clk);
    exDrive(pc, brSel, tgt, predT, predPc);
    exCheck(tag, expMp, expRed);
    @(negedge i_clk);
    exIdle();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    i_rst_n     = 1'b0;
    i_if_pc     = 32'h100;
    exIdle();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // Reset state
    lookup("rst_lookup", 32'h100, 1'b0, 32'h104);
    cntCheck("rst", 0, 0);
    exCheck("rst_idle", 1'b0, 32'd0);
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // First taken BEQ allocates; same-cycle lookup still sees the old table
    @(negedge i_clk);
    exDrive(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exCheck("alloc", 1'b1, 32'h80);
    lookup("alloc_same", 32'h100, 1'b0, 32'h104);
    @(negedge i_clk);
    exIdle();
    lookup("alloc_next", 32'h100, 1'b1, 32'h80);
    cntCheck("alloc", 1, 1);

    // Two more correctly predicted taken (ctr 11, 11), then not-taken (ctr 10)
    exStep("t2", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'd0);
    exStep("t3", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'd0);
    cntCheck("t3", 3, 1);
    exStep("nt1", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    lookup("nt1", 32'h100, 1'b1, 32'h80);
    exStep("nt2", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104);
    lookup("nt2", 32'h100, 1'b0, 32'h104);
    cntCheck("nt2", 5, 3);

    // Re-train 0x100 (01 -> 10), then alias 0x200 into the same index
    exStep("retrain", 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    lookup("retrain", 32'h100, 1'b1, 32'h80);
    @(negedge i_clk);
    exDrive(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    exCheck("alias", 1'b1, 32'h300);
    lookup("alias_same", 32'h200, 1'b0, 32'h204);
    @(negedge i_clk);
    exIdle();
    lookup("alias_new", 32'h200, 1'b1, 32'h300);
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    cntCheck("alias", 7, 5);

    // JALR with right direction but wrong target
    exStep("jalr", 32'h40, 1'b1, 32'h94, 1'b1, 32'h90, 1'b1, 32'h94);
    lookup("jalr", 32'h40, 1'b1, 32'h94);
    cntCheck("jalr", 8, 6);

    // Same inputs as a bubble: nothing happens
    @(negedge i_clk);
    exDrive(32'h40, 1'b1, 32'h94, 1'b1, 32'h90);
    i_ex_valid = 1'b0;
    exCheck("bubble", 1'b0, 32'd0);
    @(negedge i_clk);
    exIdle();
    cntCheck("bubble", 8, 6);

    // Not-taken miss: no flush, no allocation
    exStep("ntmiss", 32'h300, 1'b0, 32'h500, 1'b0, 32'h304, 1'b0, 32'd0);
    lookup("ntmiss", 32'h300, 1'b0, 32'h304);
    cntCheck("ntmiss", 9, 6);

    // Asynchronous reset mid-update, held across a rising edge
    @(negedge i_clk);
    exDrive(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    i_if_pc = 32'h200;
    #2;
    i_rst_n = 1'b0;
    lookup("arst_now", 32'h200, 1'b0, 32'h204);
    exCheck("arst_now", 1'b0, 32'd0);
    cntCheck("arst_now", 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exIdle();
    lookup("arst_40", 32'h40, 1'b0, 32'h44);
    lookup("arst_200", 32'h200, 1'b0, 32'h204);
    cntCheck("arst_after", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
